// File: rtl/clause_stream_memory_if.sv
// -----------------------------------------------------------------------------
// clause_stream_memory_if
// Row-stream handshake between the clause memory (master) and its consumer
// (slave). Instance parameters must match the ROW_WIDTH / PTR_BITS that the
// clause_stream_memory instance derives from its own parameters.
//   out_valid : master -> slave, out_data/out_row/out_last are valid
//   out_ready : slave  -> master, consumer accepts the presented row
//   out_data  : master -> slave, presented clause row
//   out_row   : master -> slave, index of the presented row
//   out_last  : master -> slave, presented row is the last of the pass
// -----------------------------------------------------------------------------
interface clause_stream_memory_if #(
    parameter int ROW_WIDTH = 432,
    parameter int PTR_BITS  = 2
);
    logic                 out_valid;
    logic                 out_ready;
    logic [ROW_WIDTH-1:0] out_data;
    logic [PTR_BITS-1:0]  out_row;
    logic                 out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/clause_stream_memory.sv
// -----------------------------------------------------------------------------
// clause_stream_memory
// Row-organised clause store that streams its rows to a consumer over a
// valid/ready handshake, either as a single pass or looping continuously.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data : row write port (accepted only while IDLE)
//   num_rows            : active rows per pass, sampled on start (clamped)
//   loop_mode           : 1 = wrap to row 0 after the last row, sampled on start
//   start, stop         : begin / abort streaming (stop wins over start)
//   strm (master)       : out_valid/out_ready/out_data/out_row/out_last
//   busy                : streaming is in progress
//   pass_done           : one-cycle pulse when the last row of a pass transfers
//   pass_count          : passes completed since start (wraps)
//   wr_err              : one-cycle pulse after a write attempted while busy
// -----------------------------------------------------------------------------
module clause_stream_memory #(
    parameter int NUM_CLAUSES           = 64,
    parameter int VAR_ID_BITS           = 8,
    parameter int NUM_CLAUSES_PER_CYCLE = 16,
    parameter int NUM_VARS_PER_CLAUSE   = 3,
    parameter int PASS_CNT_BITS         = 16,
    localparam int ROW_WIDTH = (VAR_ID_BITS + 1) * NUM_VARS_PER_CLAUSE * NUM_CLAUSES_PER_CYCLE,
    localparam int NUM_ROWS  = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
    localparam int PTR_BITS  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [PTR_BITS-1:0]      wr_addr,
    input  logic [ROW_WIDTH-1:0]     wr_data,
    input  logic [PTR_BITS:0]        num_rows,
    input  logic                     loop_mode,
    input  logic                     start,
    input  logic                     stop,
    clause_stream_memory_if.master   strm,
    output logic                     busy,
    output logic                     pass_done,
    output logic [PASS_CNT_BITS-1:0] pass_count,
    output logic                     wr_err
);

    localparam logic [PTR_BITS:0] MAX_ROWS = (PTR_BITS + 1)'(NUM_ROWS);
    localparam logic [PTR_BITS:0] ONE_ROW  = (PTR_BITS + 1)'(1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    // Row storage: never reset so contents survive a reset mid-stream.
    logic [ROW_WIDTH-1:0] mem_q [NUM_ROWS];

    state_t                 state_q,    state_d;
    logic                   valid_q,    valid_d;
    logic [ROW_WIDTH-1:0]   data_q,     data_d;
    logic [PTR_BITS-1:0]    row_q,      row_d;
    logic                   last_q,     last_d;
    logic [PTR_BITS:0]      nrows_q,    nrows_d;
    logic                   loop_q,     loop_d;
    logic [PASS_CNT_BITS-1:0] pass_cnt_q, pass_cnt_d;
    logic                   pass_done_q, pass_done_d;
    logic                   wr_err_q,   wr_err_d;

    logic                   xfer;
    logic [PTR_BITS-1:0]    row_inc;
    logic [PTR_BITS:0]      nrows_clamped;
    logic                   wr_ok;

    assign xfer          = valid_q && strm.out_ready;
    assign row_inc       = row_q + PTR_BITS'(1);
    assign nrows_clamped = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
    // Guard against addresses beyond NUM_ROWS when it is not a power of two.
    assign wr_ok         = wr_en && (state_q == S_IDLE) && ({1'b0, wr_addr} < MAX_ROWS);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        data_d      = data_q;
        row_d       = row_q;
        last_d      = last_q;
        nrows_d     = nrows_q;
        loop_d      = loop_q;
        pass_cnt_d  = pass_cnt_q;
        pass_done_d = 1'b0;
        wr_err_d    = wr_en && (state_q == S_RUN);

        case (state_q)
            S_IDLE: begin
                if (start && !stop && (num_rows != '0)) begin
                    state_d    = S_RUN;
                    valid_d    = 1'b1;
                    row_d      = '0;
                    data_d     = mem_q[0];
                    last_d     = (nrows_clamped == ONE_ROW);
                    nrows_d    = nrows_clamped;
                    loop_d     = loop_mode;
                    pass_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    if (last_q) begin
                        pass_done_d = 1'b1;
                        pass_cnt_d  = pass_cnt_q + PASS_CNT_BITS'(1);
                        if (loop_q) begin
                            row_d  = '0;
                            data_d = mem_q[0];
                            last_d = (nrows_q == ONE_ROW);
                        end else begin
                            state_d = S_IDLE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end
                    end else begin
                        row_d  = row_inc;
                        data_d = mem_q[row_inc];
                        last_d = (({1'b0, row_inc} + ONE_ROW) == nrows_q);
                    end
                end
                // Abort overrides any advance; the presented row stays on
                // out_data/out_row while out_valid is low.
                if (stop) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    row_d   = row_q;
                    data_d  = data_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            valid_q     <= 1'b0;
            data_q      <= '0;
            row_q       <= '0;
            last_q      <= 1'b0;
            nrows_q     <= '0;
            loop_q      <= 1'b0;
            pass_cnt_q  <= '0;
            pass_done_q <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            row_q       <= row_d;
            last_q      <= last_d;
            nrows_q     <= nrows_d;
            loop_q      <= loop_d;
            pass_cnt_q  <= pass_cnt_d;
            pass_done_q <= pass_done_d;
            wr_err_q    <= wr_err_d;
        end
    end

    assign strm.out_valid = valid_q;
    assign strm.out_data  = data_q;
    assign strm.out_row   = row_q;
    assign strm.out_last  = last_q;
    assign busy           = (state_q == S_RUN);
    assign pass_done      = pass_done_q;
    assign pass_count     = pass_cnt_q;
    assign wr_err         = wr_err_q;

endmodule
